// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-pattern detector with elaboration-time KMP transitions
module seq_detector_param #(
   parameter int             N       = 4,
   parameter logic [N-1:0]   PATTERN = 4'b1011,
   parameter int             OVERLAP = 1,
   parameter int             CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  din,
   input  logic                  clr_cnt,
   output logic                  match,
   output logic [CNT_W-1:0]      match_count,
   output logic [$clog2(N)-1:0]  progress
);

   localparam int               PW      = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (N < 2 || N > 16 || CNT_W < 1) begin : g_bad_params
      $error("seq_detector_param: N must be in 2..16 and CNT_W must be >= 1");
   end

   // Bit i of the pattern in line order (i=0 is the first bit expected).
   function automatic logic pat_bit(input int i);
      logic [N-1:0] sh;
      sh = PATTERN >> (N - 1 - i);
      return sh[0];
   endfunction

   // KMP failure: longest proper suffix of the first len pattern bits that is also a prefix.
   function automatic int fail_len(input int len);
      int f;
      bit ok;
      f = 0;
      for (int l = len - 1; l >= 1; l--) begin
         if (f == 0) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
               if (pat_bit(i) != pat_bit(len - l + i)) ok = 1'b0;
            end
            if (ok) f = l;
         end
      end
      return f;
   endfunction

   // Next state from state k on bit b; a full match folds straight back to F(N) or 0.
   function automatic int step(input int k, input logic b);
      int j;
      int r;
      j = k;
      if (k == N - 1 && pat_bit(k) == b) begin
         r = (OVERLAP != 0) ? fail_len(N) : 0;
      end else begin
         while (j > 0 && pat_bit(j) != b) j = fail_len(j);
         r = (pat_bit(j) == b) ? j + 1 : 0;
      end
      return r;
   endfunction

   logic [PW-1:0] nxt0 [N];
   logic [PW-1:0] nxt1 [N];

   for (genvar k = 0; k < N; k++) begin : g_tab
      localparam int D0 = step(k, 1'b0);
      localparam int D1 = step(k, 1'b1);
      assign nxt0[k] = PW'(D0);
      assign nxt1[k] = PW'(D1);
   end

   logic [PW-1:0]    progress_nxt;
   logic             hit;
   logic [CNT_W-1:0] count_nxt;

   // State register: progress, registered match pulse and saturating counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         progress    <= '0;
         match       <= 1'b0;
         match_count <= '0;
      end else begin
         progress    <= progress_nxt;
         match       <= hit;
         match_count <= count_nxt;
      end
   end

   // Next state: table lookup on enabled edges; a hit is the last pattern bit arriving in S(N-1).
   always_comb begin
      progress_nxt = progress;
      hit          = 1'b0;
      if (en) begin
         progress_nxt = din ? nxt1[progress] : nxt0[progress];
         hit          = (progress == PW'(N - 1)) && (din == PATTERN[0]);
      end
   end

   // Output: clear wins over increment; the counter sticks at all-ones.
   always_comb begin
      count_nxt = match_count;
      if (clr_cnt) begin
         count_nxt = '0;
      end else if (hit && match_count != CNT_MAX) begin
         count_nxt = match_count + CNT_W'(1);
      end
   end

endmodule
